// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with bubble insertion, flush, MAC-state feedback and a bubble counter.
// One-cycle latency; stall_mem freezes every register, stall_ex alone inserts a bubble.
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_ex,
  input  logic                stall_mem,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] ex_hilo_temp,
  input  logic [CNT_W-1:0]    ex_cnt,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [PERF_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              valid;
  } mem_pkt_t;

  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  mem_pkt_t              pkt_q, pkt_d, ex_pkt;
  logic [2*DATA_W-1:0]   hilo_temp_q, hilo_temp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PERF_W-1:0]     bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    ex_pkt       = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
                     hi: ex_hi, lo: ex_lo, valid: 1'b1};
    pkt_d        = pkt_q;
    hilo_temp_d  = hilo_temp_q;
    cnt_d        = cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (rst) begin
      pkt_d        = '0;
      hilo_temp_d  = '0;
      cnt_d        = '0;
      bubble_cnt_d = '0;
    end else if (flush) begin
      // A flush kills in-flight work but is not a bubble for perf accounting.
      pkt_d       = '0;
      hilo_temp_d = '0;
      cnt_d       = '0;
    end else if (stall_mem) begin
      // Hold; stall_ex=0 here cannot happen legally and is treated the same way.
      pkt_d = pkt_q;
    end else if (stall_ex) begin
      pkt_d       = '0;
      hilo_temp_d = ex_hilo_temp;
      cnt_d       = ex_cnt;
      if (bubble_cnt_q != {PERF_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + PERF_ONE;
      end
    end else begin
      pkt_d       = ex_pkt;
      hilo_temp_d = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    pkt_q        <= pkt_d;
    hilo_temp_q  <= hilo_temp_d;
    cnt_q        <= cnt_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  assign mem_wd      = pkt_q.wd;
  assign mem_wreg    = pkt_q.wreg;
  assign mem_wdata   = pkt_q.wdata;
  assign mem_whilo   = pkt_q.whilo;
  assign mem_hi      = pkt_q.hi;
  assign mem_lo      = pkt_q.lo;
  assign mem_valid   = pkt_q.valid;
  assign hilo_temp_o = hilo_temp_q;
  assign cnt_o       = cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed table-driven bench for ex_mem_pipe, plus counter saturation and illegal-stall sequences.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst, stall_ex, stall_mem, flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_whilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cnt;

  logic [4:0]  mem_wd, s_mem_wd;
  logic        mem_wreg, mem_whilo, mem_valid, s_mem_wreg, s_mem_whilo, s_mem_valid;
  logic [31:0] mem_wdata, mem_hi, mem_lo, s_mem_wdata, s_mem_hi, s_mem_lo;
  logic [63:0] hilo_temp_o, s_hilo_temp_o;
  logic [1:0]  cnt_o, s_cnt_o;
  logic [15:0] bubble_cnt;
  logic [3:0]  s_bubble_cnt;

  int errors = 0;
  int checks = 0;
  int illegal_seen = 0;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
  );

  ex_mem_pipe #(.PERF_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
    .mem_wd(s_mem_wd), .mem_wreg(s_mem_wreg), .mem_wdata(s_mem_wdata), .mem_whilo(s_mem_whilo),
    .mem_hi(s_mem_hi), .mem_lo(s_mem_lo), .mem_valid(s_mem_valid),
    .hilo_temp_o(s_hilo_temp_o), .cnt_o(s_cnt_o), .bubble_cnt(s_bubble_cnt)
  );

  // Stalls must be monotone toward earlier stages: MEM stalled implies EX stalled.
  always @(negedge clk) begin
    if (!rst) begin
      stall_order: assert (!(stall_mem && !stall_ex)) else illegal_seen++;
    end
  end

  typedef struct {
    logic        rst, flush, se, sm;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic [63:0] ht;
    logic [1:0]  c;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi, e_lo;
    logic        e_valid;
    logic [63:0] e_ht;
    logic [1:0]  e_c;
    logic [15:0] e_b;
  } vec_t;

  function automatic vec_t mk(
    input logic r, f, se, sm, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
    input logic whilo, input logic [31:0] hi, lo, input logic [63:0] ht, input logic [1:0] c,
    input logic [4:0] e_wd, input logic e_wreg, input logic [31:0] e_wdata, input logic e_whilo,
    input logic [31:0] e_hi, e_lo, input logic e_valid, input logic [63:0] e_ht,
    input logic [1:0] e_c, input logic [15:0] e_b);
    vec_t v;
    v.rst = r; v.flush = f; v.se = se; v.sm = sm; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
    v.whilo = whilo; v.hi = hi; v.lo = lo; v.ht = ht; v.c = c;
    v.e_wd = e_wd; v.e_wreg = e_wreg; v.e_wdata = e_wdata; v.e_whilo = e_whilo;
    v.e_hi = e_hi; v.e_lo = e_lo; v.e_valid = e_valid; v.e_ht = e_ht; v.e_c = e_c; v.e_b = e_b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.flush; stall_ex = v.se; stall_mem = v.sm;
    ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata; ex_whilo = v.whilo;
    ex_hi = v.hi; ex_lo = v.lo; ex_hilo_temp = v.ht; ex_cnt = v.c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] H1 = 64'h0000_0001_0000_0002;
  localparam logic [63:0] H2 = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] H3 = 64'h0123_4567_89AB_CDEF;

  initial begin
    vec_t vecs[$];
    vec_t v;

    // reset (2 cycles)
    vecs.push_back(mk(1,0,0,0, 5'd3,1,32'hDEADBEEF,0,0,0,0,0,  0,0,0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0, 5'd3,1,32'hDEADBEEF,0,0,0,0,0,  0,0,0,0,0,0,0,0,0,0));
    // pass-through
    vecs.push_back(mk(0,0,0,0, 5'd3,1,32'hDEADBEEF,0,0,0,0,0,  5'd3,1,32'hDEADBEEF,0,0,0,1,0,0,0));
    // three bubbles carrying MAC state
    for (int i = 1; i <= 3; i++)
      vecs.push_back(mk(0,0,1,0, 5'd3,1,32'hDEADBEEF,0,0,0,H1,2'd1,  0,0,0,0,0,0,0,H1,2'd1,16'(i)));
    // pass clears MAC state even with nonzero ex_hilo_temp
    vecs.push_back(mk(0,0,0,0, 5'd7,1,32'h12345678,0,0,0,H1,2'd1,  5'd7,1,32'h12345678,0,0,0,1,0,0,3));
    // hold for 4 cycles with changing inputs
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(0,0,1,1, 5'd8,0,32'h11111111*i,1,32'hFFFF0000,32'h0000FFFF,H2,2'd2,
                        5'd7,1,32'h12345678,0,0,0,1,0,0,3));
    // bubble loads MAC state, then flush with stall_ex clears it without counting
    vecs.push_back(mk(0,0,1,0, 5'd8,1,32'h1,0,0,0,H2,2'd2,  0,0,0,0,0,0,0,H2,2'd2,4));
    vecs.push_back(mk(0,1,1,0, 5'd8,1,32'h1,1,32'h5,32'h6,H3,2'd3,  0,0,0,0,0,0,0,0,0,4));
    // release flush
    vecs.push_back(mk(0,0,0,0, 5'd9,1,32'h0BADF00D,0,0,0,0,0,  5'd9,1,32'h0BADF00D,0,0,0,1,0,0,4));
    // HI/LO path, then reset mid-stream
    vecs.push_back(mk(0,0,0,0, 5'd0,0,32'h0,1,32'hAAAA0000,32'h0000BBBB,0,0,
                      5'd0,0,32'h0,1,32'hAAAA0000,32'h0000BBBB,1,0,0,4));
    vecs.push_back(mk(1,0,0,0, 5'd0,0,32'h0,1,32'hAAAA0000,32'h0000BBBB,0,0,  0,0,0,0,0,0,0,0,0,0));
    // reset in the middle of a multi-cycle op
    vecs.push_back(mk(0,0,1,0, 5'd4,1,32'h55,0,0,0,H3,2'd3,  0,0,0,0,0,0,0,H3,2'd3,1));
    vecs.push_back(mk(1,0,1,0, 5'd4,1,32'h55,0,0,0,H3,2'd3,  0,0,0,0,0,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      tick();
      chk($sformatf("v%0d mem_wd", i),      64'(mem_wd),      64'(v.e_wd));
      chk($sformatf("v%0d mem_wreg", i),    64'(mem_wreg),    64'(v.e_wreg));
      chk($sformatf("v%0d mem_wdata", i),   64'(mem_wdata),   64'(v.e_wdata));
      chk($sformatf("v%0d mem_whilo", i),   64'(mem_whilo),   64'(v.e_whilo));
      chk($sformatf("v%0d mem_hi", i),      64'(mem_hi),      64'(v.e_hi));
      chk($sformatf("v%0d mem_lo", i),      64'(mem_lo),      64'(v.e_lo));
      chk($sformatf("v%0d mem_valid", i),   64'(mem_valid),   64'(v.e_valid));
      chk($sformatf("v%0d hilo_temp_o", i), hilo_temp_o,      v.e_ht);
      chk($sformatf("v%0d cnt_o", i),       64'(cnt_o),       64'(v.e_c));
      chk($sformatf("v%0d bubble_cnt", i),  64'(bubble_cnt),  64'(v.e_b));
    end

    // Saturation: 20 bubbles; the 4-bit counter stops at F, the 16-bit one keeps counting.
    rst = 0; flush = 0; stall_ex = 1; stall_mem = 0;
    ex_cnt = 2'd1; ex_hilo_temp = H1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("sat%0d bubble_cnt4", i), 64'(s_bubble_cnt), 64'((i > 15) ? 15 : i));
      chk($sformatf("sat%0d bubble_cnt16", i), 64'(bubble_cnt), 64'(i));
    end
    chk("pre_illegal count", 64'(illegal_seen), 64'd0);

    // Illegal stall_mem without stall_ex: state holds, monitor flags each cycle.
    stall_ex = 0; stall_mem = 1;
    ex_cnt = 2'd2; ex_hilo_temp = H2; ex_wd = 5'd31; ex_wreg = 1; ex_wdata = 32'h77777777;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("ill%0d cnt_o", i),        64'(cnt_o),        64'd1);
      chk($sformatf("ill%0d hilo_temp_o", i),  hilo_temp_o,       H1);
      chk($sformatf("ill%0d mem_valid", i),    64'(mem_valid),    64'd0);
      chk($sformatf("ill%0d mem_wd", i),       64'(mem_wd),       64'd0);
      chk($sformatf("ill%0d bubble_cnt4", i),  64'(s_bubble_cnt), 64'd15);
      chk($sformatf("ill%0d bubble_cnt16", i), 64'(bubble_cnt),   64'd20);
    end
    chk("illegal stall count", 64'(illegal_seen), 64'd2);
    stall_mem = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX/MEM pipeline register for the MIPS core. It supersedes the plain register-file-write pass-through.
- Adds HI/LO write fields, a valid bit, per-stage stall with bubble insertion, and pipeline flush.
- Carries multi-cycle multiply-accumulate state (hilo_temp, cnt) back to EX during stalls.
- Adds a saturating bubble counter for performance monitoring.
- Sits between the ex and mem stages; control inputs come from the pipeline controller.

Parameters:
DATA_W, 32, width of GPR/HI/LO data
ADDR_W, 5, width of destination register address
CNT_W, 2, width of multi-cycle op step counter
PERF_W, 16, width of bubble performance counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stall_ex  input  1  EX stage stalled this cycle
stall_mem  input  1  MEM stage stalled this cycle
flush  input  1  kill all in-flight state (exception)
ex_wd  input  ADDR_W  destination register address
ex_wreg  input  1  GPR write enable
ex_wdata  input  DATA_W  GPR write data
ex_whilo  input  1  HI/LO write enable
ex_hi  input  DATA_W  HI write data
ex_lo  input  DATA_W  LO write data
ex_hilo_temp  input  2*DATA_W  partial multiply-accumulate result from EX
ex_cnt  input  CNT_W  multi-cycle step index from EX
mem_wd  output  ADDR_W  registered ex_wd
mem_wreg  output  1  registered ex_wreg
mem_wdata  output  DATA_W  registered ex_wdata
mem_whilo  output  1  registered ex_whilo
mem_hi  output  DATA_W  registered ex_hi
mem_lo  output  DATA_W  registered ex_lo
mem_valid  output  1  MEM holds a real instruction (not a bubble)
hilo_temp_o  output  2*DATA_W  fed back to EX for next step
cnt_o  output  CNT_W  fed back to EX for next step
bubble_cnt  output  PERF_W  number of bubbles inserted, saturating

Behaviour:
- All state updates on posedge clk. Latency is 1 cycle. No combinational path from input to output.
- Priority is rst > flush > stall decode > normal pass.
- rst=1: every output is 0, including bubble_cnt. mem_wd=0 is the NOP register address.
- flush=1 (rst=0):
  - All pipeline outputs, mem_valid, hilo_temp_o and cnt_o go to 0.
  - bubble_cnt is unchanged; a flush is not counted as a bubble.
- Normal pass (stall_ex=0, stall_mem=0):
  - Each mem_* output takes its ex_* counterpart; mem_valid<=1.
  - hilo_temp_o<=0 and cnt_o<=0, so multi-cycle state is cleared once the instruction advances.
- Bubble insert (stall_ex=1, stall_mem=0):
  - mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo and mem_valid go to 0.
  - hilo_temp_o<=ex_hilo_temp and cnt_o<=ex_cnt, preserving the accumulation step.
  - bubble_cnt increments by 1 and saturates at all-ones (no wrap).
- Hold (stall_mem=1, whatever stall_ex is):
  - All registers keep their value; bubble_cnt unchanged.
  - stall_ex=0 with stall_mem=1 is illegal, because stalls are monotone toward earlier stages. RTL treats it as hold, and the bench flags it with an assertion.
- Reset or flush mid multi-cycle op: cnt_o and hilo_temp_o clear, so EX restarts at step 0.
- Widths: hilo_temp is exactly 2*DATA_W, with no truncation. bubble_cnt is an unsigned PERF_W count.

Test Plan:
- Pass-through: rst for 2 cycles, then ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEADBEEF with no stall.
  - Cycle 0: outputs are 0.
  - Next edge: mem_wd=3, mem_wreg=1, mem_wdata=DEADBEEF, mem_valid=1.
- Bubble: stall_ex=1, stall_mem=0 for 3 cycles, ex_cnt=1, ex_hilo_temp=64'h0000_0001_0000_0002.
  - mem_wreg=0, mem_valid=0, cnt_o=1, hilo_temp_o=64'h0000000100000002.
  - bubble_cnt goes 0→3.
- Hold: load ex_wdata=32'h12345678 and pass it, then stall_ex=stall_mem=1 for 4 cycles while ex_wdata changes each cycle.
  - mem_wdata stays 12345678, bubble_cnt unchanged.
- Flush priority: flush=1 together with stall_ex=1 and stall_mem=0.
  - All outputs and cnt_o go to 0, bubble_cnt not incremented.
  - Releasing flush with no stall passes the new ex_* values.
- HI/LO path: ex_whilo=1, ex_hi=32'hAAAA0000, ex_lo=32'h0000BBBB, no stall.
  - mem_whilo=1, mem_hi=AAAA0000, mem_lo=0000BBBB.
  - Then rst=1 mid-stream: next edge all outputs are 0.
- Saturation: PERF_W=4, hold the bubble condition for 20 cycles.
  - bubble_cnt reaches 4'hF and stays there.
  - Illegal stall_ex=0 with stall_mem=1 fires the assertion and the state holds.
